// File: rtl/block_memory.sv
// Main-memory model behind the cache: whole-block reads and write-backs with a
// fixed BUSY latency, and a one-cycle DONE gap before the next request is taken.
module block_memory #(
  parameter int WORD_W     = 32,
  parameter int BLK_WORDS  = 4,
  parameter int ADDR_W     = 28,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        read,
  input  logic                        write,
  input  logic [ADDR_W-1:0]           address,
  input  logic [WORD_W*BLK_WORDS-1:0] writedata,
  output logic [WORD_W*BLK_WORDS-1:0] readdata,
  output logic                        busywait
);

  localparam int BLK_W = WORD_W * BLK_WORDS;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  logic [3:0]            counter;
  logic                  op_write;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [BLK_W-1:0]      wdata_q;
  logic                  mem_we;
  logic [BLK_W-1:0]      mem [2**DEPTH_LOG2];

  // Upper block-address bits alias onto the same stored block.
  logic unused_addr;
  assign unused_addr = ^address[ADDR_W-1:DEPTH_LOG2];

  assign mem_we = (state == BUSY) && (counter == '0) && op_write;

  // IDLE reflects the request in the same cycle so the cache stalls at once.
  always_comb begin
    busywait = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    busywait = read | write;
        BUSY:    busywait = 1'b1;
        default: busywait = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= '0;
      readdata <= '0;
      op_write <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read | write) begin
            op_write <= write;
            idx_q    <= address[DEPTH_LOG2-1:0];
            wdata_q  <= writedata;
            counter  <= 4'(LATENCY - 1);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (counter != '0) begin
            counter <= counter - 4'd1;
          end else begin
            if (!op_write) readdata <= mem[idx_q];
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage sits outside the reset domain; an aborted access leaves BUSY via
  // the async reset before mem_we can fire.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end

endmodule
